// File: rtl/pong_pkg.sv
// Shared pong definitions: game FSM states, playfield geometry and coordinate widths.
package pong_pkg;

  typedef enum logic [1:0] {StServe, StPlay, StScored, StGameOver} state_e;

  localparam int unsigned ScreenW = 640;
  localparam int unsigned ScreenH = 480;
  localparam int unsigned XW      = 10;
  localparam int unsigned YW      = 9;
  // All geometry compares are done at this width so sums never wrap.
  localparam int unsigned CW      = 11;

  typedef logic [CW-1:0] cmp_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/ball_hit_zone.sv
// Paddle contact check and hit-zone classification: outer quarters deflect steeply toward
// that paddle edge, the middle half returns a shallow ball.
module ball_hit_zone
  import pong_pkg::*;
(
  input  logic [YW-1:0] ball_y,
  input  logic [5:0]    ball_width,
  input  logic [8:0]    paddle_y,
  input  logic [8:0]    paddle_length,
  output logic          overlap,
  output logic [1:0]    dy,
  output logic          edge_hit,
  output logic          edge_up
);

  cmp_t b_top, b_bot, b_mid, p_top, p_bot, q1, q3;
  logic edge_dn;

  always_comb begin
    b_top = cmp_t'(ball_y);
    b_bot = b_top + cmp_t'(ball_width);
    b_mid = b_top + (cmp_t'(ball_width) >> 1);
    p_top = cmp_t'(paddle_y);
    p_bot = p_top + cmp_t'(paddle_length);
    // offset = b_mid - p_top is never formed; both sides are shifted by p_top instead.
    q1    = p_top + (cmp_t'(paddle_length) >> 2);
    q3    = p_top + ((cmp_t'(paddle_length) * cmp_t'(3)) >> 2);
  end

  assign overlap  = (b_bot > p_top) && (b_top < p_bot);
  assign edge_up  = b_mid < q1;
  assign edge_dn  = b_mid > q3;
  assign edge_hit = edge_up || edge_dn;
  assign dy       = edge_hit ? 2'd3 : 2'd1;

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball engine: per-tick motion, wall and paddle bounces, miss detection, scoring and the
// serve / play / scored / game-over sequence.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W    = ScreenW,
  parameter int unsigned SCREEN_H    = ScreenH,
  parameter int unsigned DX_INIT     = 2,
  parameter int unsigned DX_MAX      = 8,
  parameter int unsigned PAUSE_TICKS = 60,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          serve,
  input  logic          new_game,
  input  logic [5:0]    wall_width,
  input  logic [5:0]    ball_width,
  input  logic [5:0]    paddle_width,
  input  logic [8:0]    paddle_length,
  input  logic [8:0]    left_y,
  input  logic [8:0]    right_y,
  output logic [9:0]    ball_x,
  output logic [8:0]    ball_y,
  output logic          ball_direction,
  output logic [3:0]    score_left,
  output logic [3:0]    score_right,
  output logic          point,
  output logic          game_over
);

  localparam int unsigned PCW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

  state_e state_q, state_d;

  logic [XW-1:0]  pos_x_q, pos_x_d;
  logic [YW-1:0]  pos_y_q, pos_y_d;
  logic           at_centre_q, at_centre_d;
  logic           dir_q, dir_d;
  logic [3:0]     dx_q, dx_d;
  logic [1:0]     dy_q, dy_d;
  logic           up_q, up_d;
  logic [3:0]     score_l_q, score_l_d, score_r_q, score_r_d;
  logic           point_q, point_d;
  logic [PCW-1:0] pause_q, pause_d;

  logic play_step, pause_tick, pause_done, clear_game;

  // The centred position tracks ball_width live, so reset needs no input-dependent load value.
  logic [XW-1:0] centre_x, cur_x, step_x;
  logic [YW-1:0] centre_y, cur_y, step_y;
  cmp_t          x_c, y_c, bw_c, ww_c, pw_c, dx_c, dy_c;

  logic       ovl_l, ovl_r, ze_l, ze_r, zu_l, zu_r;
  logic [1:0] zdy_l, zdy_r;

  logic       wall_hit, wall_up, hit, miss, win;
  logic       step_dir, step_up, zone_edge, zone_up;
  logic [1:0] step_dy, zone_dy;
  logic [3:0] dx_inc, score_l_inc, score_r_inc;

  assign centre_x = XW'((cmp_t'(SCREEN_W) - cmp_t'(ball_width)) >> 1);
  assign centre_y = YW'((cmp_t'(SCREEN_H) - cmp_t'(ball_width)) >> 1);
  assign cur_x    = at_centre_q ? centre_x : pos_x_q;
  assign cur_y    = at_centre_q ? centre_y : pos_y_q;

  assign x_c  = cmp_t'(cur_x);
  assign y_c  = cmp_t'(cur_y);
  assign bw_c = cmp_t'(ball_width);
  assign ww_c = cmp_t'(wall_width);
  assign pw_c = cmp_t'(paddle_width);
  assign dx_c = cmp_t'(dx_q);
  assign dy_c = cmp_t'(dy_q);

  ball_hit_zone u_zone_left (
    .ball_y        (cur_y),
    .ball_width    (ball_width),
    .paddle_y      (left_y),
    .paddle_length (paddle_length),
    .overlap       (ovl_l),
    .dy            (zdy_l),
    .edge_hit      (ze_l),
    .edge_up       (zu_l)
  );

  ball_hit_zone u_zone_right (
    .ball_y        (cur_y),
    .ball_width    (ball_width),
    .paddle_y      (right_y),
    .paddle_length (paddle_length),
    .overlap       (ovl_r),
    .dy            (zdy_r),
    .edge_hit      (ze_r),
    .edge_up       (zu_r)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StServe;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StServe:    if (serve) state_d = StPlay;
      StPlay:     if (tick && miss) state_d = win ? StGameOver : StScored;
      StScored:   if (pause_done) state_d = StPlay;
      StGameOver: if (new_game) state_d = StServe;
      default:    state_d = StServe;
    endcase
  end

  always_comb begin
    play_step  = 1'b0;
    pause_tick = 1'b0;
    pause_done = 1'b0;
    clear_game = 1'b0;
    game_over  = 1'b0;
    unique case (state_q)
      StPlay:     play_step = tick;
      StScored: begin
        pause_tick = tick;
        pause_done = tick && (pause_q == PCW'(PAUSE_TICKS - 1));
      end
      StGameOver: begin
        game_over  = 1'b1;
        clear_game = new_game;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- motion step
  always_comb begin
    step_y   = cur_y;
    wall_hit = 1'b0;
    wall_up  = up_q;
    if (up_q) begin
      if (y_c < ww_c + dy_c) begin
        step_y   = YW'(ww_c);
        wall_hit = 1'b1;
        wall_up  = 1'b0;
      end else begin
        step_y = YW'(y_c - dy_c);
      end
    end else if (y_c + bw_c + dy_c > cmp_t'(SCREEN_H) - ww_c) begin
      step_y   = YW'(cmp_t'(SCREEN_H) - ww_c - bw_c);
      wall_hit = 1'b1;
      wall_up  = 1'b1;
    end else begin
      step_y = YW'(y_c + dy_c);
    end
  end

  always_comb begin
    step_x    = cur_x;
    step_dir  = dir_q;
    hit       = 1'b0;
    miss      = 1'b0;
    zone_dy   = dy_q;
    zone_edge = 1'b0;
    zone_up   = 1'b0;
    if (dir_q) begin
      if (x_c < pw_c + dx_c) begin
        if (ovl_l) begin
          step_x    = XW'(pw_c);
          step_dir  = 1'b0;
          hit       = 1'b1;
          zone_dy   = zdy_l;
          zone_edge = ze_l;
          zone_up   = zu_l;
        end else begin
          miss = 1'b1;
        end
      end else begin
        step_x = XW'(x_c - dx_c);
      end
    end else begin
      if (x_c + bw_c + dx_c > cmp_t'(SCREEN_W) - pw_c) begin
        if (ovl_r) begin
          step_x    = XW'(cmp_t'(SCREEN_W) - pw_c - bw_c);
          step_dir  = 1'b1;
          hit       = 1'b1;
          zone_dy   = zdy_r;
          zone_edge = ze_r;
          zone_up   = zu_r;
        end else begin
          miss = 1'b1;
        end
      end else begin
        step_x = XW'(x_c + dx_c);
      end
    end
  end

  assign dx_inc      = (dx_q >= 4'(DX_MAX)) ? 4'(DX_MAX) : dx_q + 4'd1;
  assign step_dy     = hit ? zone_dy : dy_q;
  // On a corner hit the wall owns the vertical direction; the paddle still sets the speed.
  assign step_up     = wall_hit ? wall_up : ((hit && zone_edge) ? zone_up : up_q);
  assign score_l_inc = sat_inc(score_l_q, 4'(WIN_SCORE));
  assign score_r_inc = sat_inc(score_r_q, 4'(WIN_SCORE));
  assign win         = miss && (dir_q ? (score_r_inc == 4'(WIN_SCORE))
                                      : (score_l_inc == 4'(WIN_SCORE)));

  // ---------------------------------------------------------------- datapath update
  always_comb begin
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    at_centre_d = at_centre_q;
    dir_d       = dir_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    up_d        = up_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    point_d     = 1'b0;
    pause_d     = pause_q;

    if (play_step) begin
      if (miss) begin
        // The ball freezes where it missed; dir already points at the conceding player.
        point_d = 1'b1;
        if (dir_q) score_r_d = score_r_inc;
        else       score_l_d = score_l_inc;
        if (win) begin
          at_centre_d = 1'b1;
          dx_d        = 4'(DX_INIT);
          dy_d        = 2'd1;
        end
      end else begin
        pos_x_d     = step_x;
        pos_y_d     = step_y;
        at_centre_d = 1'b0;
        dir_d       = step_dir;
        dx_d        = hit ? dx_inc : dx_q;
        dy_d        = step_dy;
        up_d        = step_up;
      end
    end

    if (pause_tick) begin
      if (pause_done) begin
        pause_d     = '0;
        at_centre_d = 1'b1;
        dx_d        = 4'(DX_INIT);
        dy_d        = 2'd1;
        up_d        = ~up_q;
      end else begin
        pause_d = pause_q + PCW'(1);
      end
    end

    if (clear_game) begin
      score_l_d   = '0;
      score_r_d   = '0;
      at_centre_d = 1'b1;
      dx_d        = 4'(DX_INIT);
      dy_d        = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      at_centre_q <= 1'b1;
      dir_q       <= 1'b1;
      dx_q        <= 4'(DX_INIT);
      dy_q        <= 2'd1;
      up_q        <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      point_q     <= 1'b0;
      pause_q     <= '0;
    end else begin
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      at_centre_q <= at_centre_d;
      dir_q       <= dir_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      up_q        <= up_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      point_q     <= point_d;
      pause_q     <= pause_d;
    end
  end

  assign ball_x         = cur_x;
  assign ball_y         = cur_y;
  assign ball_direction = dir_q;
  assign score_left     = score_l_q;
  assign score_right    = score_r_q;
  assign point          = point_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: a behavioural game model drives paddles to rally or miss and feeds a
// scoreboard that is compared against the DUT after every clock.
module tb_ball_ctrl;

  localparam int W = 640, H = 480, WW = 10, BW = 8, PW = 8, LEN = 64;
  localparam int DXI = 2, DXM = 8, PT = 60, WIN = 9;
  localparam int CX = (W - BW) / 2, CY = (H - BW) / 2;
  localparam int MS_SERVE = 0, MS_PLAY = 1, MS_SCORED = 2, MS_GO = 3;

  logic       clk = 1'b0, reset = 1'b0;
  logic       tick = 1'b0, serve = 1'b0, new_game = 1'b0;
  logic [5:0] wall_width, ball_width, paddle_width;
  logic [8:0] paddle_length, left_y, right_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       ball_direction, point, game_over;
  logic [3:0] score_left, score_right;

  ball_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .serve          (serve),
    .new_game       (new_game),
    .wall_width     (wall_width),
    .ball_width     (ball_width),
    .paddle_width   (paddle_width),
    .paddle_length  (paddle_length),
    .left_y         (left_y),
    .right_y        (right_y),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .ball_direction (ball_direction),
    .score_left     (score_left),
    .score_right    (score_right),
    .point          (point),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int dir; int sl; int sr; int pt; int go;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0, n_fails = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fails++;
      if (n_fails <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  int m_state, m_x, m_y, m_dir, m_dx, m_dy, m_up, m_sl, m_sr, m_pt, m_pause;
  bit hit_ev, pt_ev;

  task automatic model_reset();
    m_state = MS_SERVE; m_x = CX; m_y = CY; m_dir = 1; m_dx = DXI; m_dy = 1;
    m_up = 0; m_sl = 0; m_sr = 0; m_pt = 0; m_pause = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit ng, input int ly, input int ry);
    int nx, ny, ndir, ndx, ndy, nup, py, off;
    bit wb, miss, hit;
    m_pt = 0; hit_ev = 0; pt_ev = 0;
    case (m_state)
      MS_SERVE: if (s) m_state = MS_PLAY;
      MS_PLAY: if (t) begin
        nx = m_x; ny = m_y; ndir = m_dir; ndx = m_dx; ndy = m_dy; nup = m_up;
        wb = 0; miss = 0; hit = 0; py = 0;
        if (m_up == 1) begin
          if (m_y - m_dy < WW) begin ny = WW; nup = 0; wb = 1; end
          else ny = m_y - m_dy;
        end else begin
          if (m_y + BW + m_dy > H - WW) begin ny = H - WW - BW; nup = 1; wb = 1; end
          else ny = m_y + m_dy;
        end
        if (m_dir == 1) begin
          if (m_x - m_dx < PW) begin
            if (m_y + BW > ly && m_y < ly + LEN) begin nx = PW; ndir = 0; hit = 1; py = ly; end
            else miss = 1;
          end else nx = m_x - m_dx;
        end else begin
          if (m_x + BW + m_dx > W - PW) begin
            if (m_y + BW > ry && m_y < ry + LEN) begin nx = W - PW - BW; ndir = 1; hit = 1; py = ry; end
            else miss = 1;
          end else nx = m_x + m_dx;
        end
        if (hit) begin
          ndx = (m_dx + 1 > DXM) ? DXM : m_dx + 1;
          off = m_y + BW / 2 - py;
          if (off < LEN / 4) begin ndy = 3; if (!wb) nup = 1; end
          else if (off > (3 * LEN) / 4) begin ndy = 3; if (!wb) nup = 0; end
          else ndy = 1;
        end
        if (miss) begin
          m_pt = 1; pt_ev = 1;
          if (m_dir == 1) m_sr = m_sr + 1; else m_sl = m_sl + 1;
          if (m_sl == WIN || m_sr == WIN) begin
            m_state = MS_GO; m_x = CX; m_y = CY; m_dx = DXI; m_dy = 1;
          end else m_state = MS_SCORED;
        end else begin
          m_x = nx; m_y = ny; m_dir = ndir; m_dx = ndx; m_dy = ndy; m_up = nup;
          hit_ev = hit;
        end
      end
      MS_SCORED: if (t) begin
        if (m_pause == PT - 1) begin
          m_pause = 0; m_x = CX; m_y = CY; m_dx = DXI; m_dy = 1; m_up = 1 - m_up;
          m_state = MS_PLAY;
        end else m_pause++;
      end
      default: if (ng) begin
        m_sl = 0; m_sr = 0; m_x = CX; m_y = CY; m_dx = DXI; m_dy = 1; m_state = MS_SERVE;
      end
    endcase
  endtask

  // ---------------------------------------------------------------- paddle policy
  int off_l = 30, off_r = 30, hits_pt = 0, target = 1, pts = 0;

  function automatic logic [8:0] follow(input int off);
    int v;
    v = m_y + BW / 2 - off;
    if (v < 0) v = 0;
    if (v > 511) v = 511;
    return 9'(v);
  endfunction

  function automatic logic [8:0] far_pos();
    return (m_y > 240) ? 9'd0 : 9'd400;
  endfunction

  task automatic drive_cycle(input bit t, input bit s, input bit ng);
    exp_t e;
    bit cond;
    tick = t; serve = s; new_game = ng;
    cond = (hits_pt >= target) && (m_dir == 0 || (pts % 3 == 0));
    left_y  = (m_dir == 1 && cond) ? far_pos() : follow(off_l);
    right_y = (m_dir == 0 && cond) ? far_pos() : follow(off_r);
    @(posedge clk);
    #1;
    model_step(t, s, ng, int'(left_y), int'(right_y));
    if (hit_ev) begin
      hits_pt++;
      off_l = $urandom_range(0, LEN - 1);
      off_r = $urandom_range(0, LEN - 1);
    end
    if (pt_ev) begin
      hits_pt = 0; pts++; target = $urandom_range(0, 3);
    end
    sb_q.push_back('{m_x, m_y, m_dir, m_sl, m_sr, m_pt, (m_state == MS_GO) ? 1 : 0});
    e = sb_q.pop_front();
    check_eq("ball_x", ball_x, e.x);
    check_eq("ball_y", ball_y, e.y);
    check_eq("ball_direction", ball_direction, e.dir);
    check_eq("score_left", score_left, e.sl);
    check_eq("score_right", score_right, e.sr);
    check_eq("point", point, e.pt);
    check_eq("game_over", game_over, e.go);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_x"}, ball_x, CX);
    check_eq({tag, "_y"}, ball_y, CY);
    check_eq({tag, "_dir"}, ball_direction, 1);
    check_eq({tag, "_sl"}, score_left, 0);
    check_eq({tag, "_sr"}, score_right, 0);
    check_eq({tag, "_point"}, point, 0);
    check_eq({tag, "_go"}, game_over, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wall_width = 6'(WW); ball_width = 6'(BW); paddle_width = 6'(PW);
    paddle_length = 9'(LEN); left_y = 9'd0; right_y = 9'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Serve, then three ticks from centre.
    drive_cycle(0, 1, 0);
    repeat (3) drive_cycle(1, 0, 0);
    check_eq("serve3_x", ball_x, 310);
    check_eq("serve3_y", ball_y, 239);
    check_eq("serve3_dir", ball_direction, 1);

    // Full game with ticks on alternate cycles and stray serve/new_game pulses.
    while (m_state != MS_GO && cyc < 60000)
      drive_cycle(cyc % 2 == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    check_eq("reach_game_over", game_over, 1);
    check_eq("winner_score", (score_left > score_right) ? score_left : score_right, WIN);

    repeat (10) drive_cycle(1, 1, 0);
    drive_cycle(0, 0, 1);
    check_eq("new_game_sl", score_left, 0);
    check_eq("new_game_sr", score_right, 0);
    repeat (4) drive_cycle(1, 0, 0);
    check_eq("serve_idle_x", ball_x, CX);

    // Mid-flight asynchronous reset between clock edges.
    drive_cycle(0, 1, 0);
    repeat (21) drive_cycle(1, 0, 0);
    #3;
    reset = 1'b0;
    tick = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    sb_q.delete();
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    reset = 1'b1;
    hits_pt = 0;
    repeat (3) drive_cycle(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
